// File: rtl/mem_io_bridge.sv
// Memory-mapped bus target: decodes CPU requests onto a synchronous RAM, an LED
// register and a synchronised switch port, with a sticky error flag and access counters.
module mem_io_bridge #(
  parameter int unsigned           ADDR_W    = 9,
  parameter int unsigned           DATA_W    = 16,
  parameter int unsigned           RAM_WORDS = 256,
  parameter logic [ADDR_W-1:0]     LED_ADDR  = 9'h100,
  parameter logic [ADDR_W-1:0]     SW_ADDR   = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  input  logic [7:0]        sw,
  output logic [7:0]        led,
  output logic              bus_err,
  output logic [7:0]        rd_cnt,
  output logic [7:0]        wr_cnt
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_ILL   = 2'b11
  } cmd_e;

  cmd_e              cmd;
  logic              is_ram;
  logic              is_led;
  logic              is_sw;
  logic [RAM_AW-1:0] ram_idx;
  logic [7:0]        sw_meta;
  logic [7:0]        sw_sync;
  logic [DATA_W-1:0] ram [RAM_WORDS];

  always_comb begin
    cmd     = cmd_e'(mem_cmd);
    is_ram  = ({1'b0, mem_addr} < (ADDR_W+1)'(RAM_WORDS));
    is_led  = (mem_addr == LED_ADDR);
    is_sw   = (mem_addr == SW_ADDR);
    ram_idx = mem_addr[RAM_AW-1:0];
  end

  // RAM array carries no reset; writes are still suppressed while reset is held low.
  always_ff @(posedge clk) begin
    if (reset && cmd == CMD_WRITE && is_ram)
      ram[ram_idx] <= write_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data <= '0;
      led       <= '0;
      bus_err   <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      unique case (cmd)
        CMD_READ: begin
          if (rd_cnt != 8'hFF)
            rd_cnt <= rd_cnt + 8'd1;
          if (is_ram)
            read_data <= ram[ram_idx];
          else if (is_led)
            read_data <= {{(DATA_W-8){1'b0}}, led};
          else if (is_sw)
            read_data <= {{(DATA_W-8){1'b0}}, sw_sync};
          else begin
            read_data <= '0;
            bus_err   <= 1'b1;
          end
        end
        CMD_WRITE: begin
          if (wr_cnt != 8'hFF)
            wr_cnt <= wr_cnt + 8'd1;
          if (is_led)
            led <= write_data[7:0];
          else if (!is_ram)
            bus_err <= 1'b1;
        end
        CMD_ILL:  bus_err <= 1'b1;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: a per-edge reference model compared every
// negative clock edge, plus literal expectations along a directed sequence.
module tb_mem_io_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic        bus_err;
  logic [7:0]  rd_cnt;
  logic [7:0]  wr_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  mem_io_bridge #(
    .ADDR_W   (9),
    .DATA_W   (16),
    .RAM_WORDS(256),
    .LED_ADDR (9'h100),
    .SW_ADDR  (9'h140)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .write_data(write_data),
    .read_data (read_data),
    .sw        (sw),
    .led       (led),
    .bus_err   (bus_err),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: address map and counter rules stated directly.
  logic [15:0] m_rd;
  bit          m_rd_known;
  logic [7:0]  m_led;
  bit          m_err;
  int          m_rc, m_wc;
  logic [7:0]  m_sw_hist [2];
  logic [15:0] m_ram  [512];
  bit          m_ramv [512];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rd <= 16'h0; m_rd_known <= 1'b1; m_led <= 8'h0; m_err <= 1'b0;
      m_rc <= 0; m_wc <= 0; m_sw_hist[0] <= 8'h0; m_sw_hist[1] <= 8'h0;
    end else begin
      m_sw_hist[0] <= sw;
      m_sw_hist[1] <= m_sw_hist[0];
      if (mem_cmd == 2'b01) begin
        m_rc <= (m_rc >= 255) ? 255 : m_rc + 1;
        m_rd_known <= 1'b1;
        if (int'(mem_addr) < 256) begin
          m_rd <= m_ram[mem_addr];
          m_rd_known <= m_ramv[mem_addr];
        end else if (mem_addr == 9'h100) m_rd <= {8'h0, m_led};
        else if (mem_addr == 9'h140) m_rd <= {8'h0, m_sw_hist[1]};
        else begin
          m_rd <= 16'h0; m_err <= 1'b1;
        end
      end else if (mem_cmd == 2'b10) begin
        m_wc <= (m_wc >= 255) ? 255 : m_wc + 1;
        if (int'(mem_addr) < 256) begin
          m_ram[mem_addr] <= write_data; m_ramv[mem_addr] <= 1'b1;
        end else if (mem_addr == 9'h100) m_led <= write_data[7:0];
        else m_err <= 1'b1;
      end else if (mem_cmd == 2'b11) begin
        m_err <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      if (m_rd_known) chk("model read_data", 32'(read_data), 32'(m_rd));
      chk("model led", 32'(led), 32'(m_led));
      chk("model bus_err", 32'(bus_err), 32'(m_err));
      chk("model rd_cnt", 32'(rd_cnt), 32'(m_rc));
      chk("model wr_cnt", 32'(wr_cnt), 32'(m_wc));
    end
  end

  // Present one request, then return just after the edge that samples it.
  task automatic cyc(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    mem_cmd = c; mem_addr = a; write_data = d;
    @(posedge clk);
    #1;
    mem_cmd = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int unsigned i = 0; i < 512; i++) m_ramv[i] = 1'b0;
    reset = 1'b1; sw = 8'h00;
    mem_cmd = 2'b10; mem_addr = 9'h100; write_data = 16'h00FF;
    #2 reset = 1'b0;
    cmp_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset led", 32'(led), 32'h0);
    chk("reset read_data", 32'(read_data), 32'h0);
    chk("reset bus_err", 32'(bus_err), 32'h0);
    chk("reset rd_cnt", 32'(rd_cnt), 32'h0);
    chk("reset wr_cnt", 32'(wr_cnt), 32'h0);
    mem_cmd = 2'b00;
    reset = 1'b1;

    cyc(2'b10, 9'h005, 16'hD005);
    chk("ram wr_cnt", 32'(wr_cnt), 32'd1);
    cyc(2'b01, 9'h005, 16'h0);
    chk("ram roundtrip", 32'(read_data), 32'hD005);
    chk("ram rd_cnt", 32'(rd_cnt), 32'd1);

    cyc(2'b10, 9'h0FF, 16'hBEEF);
    cyc(2'b01, 9'h0FF, 16'h0);
    chk("ram top word", 32'(read_data), 32'hBEEF);

    cyc(2'b10, 9'h100, 16'h12A5);
    chk("led write", 32'(led), 32'hA5);
    cyc(2'b01, 9'h100, 16'h0);
    chk("led readback", 32'(read_data), 32'h00A5);
    cyc(2'b00, 9'h005, 16'h0);
    chk("mnone hold", 32'(read_data), 32'h00A5);

    sw = 8'h3C;
    cyc(2'b01, 9'h140, 16'h0);
    chk("sw edge+1", 32'(read_data), 32'h0000);
    cyc(2'b01, 9'h140, 16'h0);
    chk("sw edge+2", 32'(read_data), 32'h0000);
    cyc(2'b01, 9'h140, 16'h0);
    chk("sw edge+3", 32'(read_data), 32'h003C);
    chk("no error yet", 32'(bus_err), 32'h0);

    reset = 1'b0; #2 reset = 1'b1;
    cyc(2'b10, 9'h140, 16'h1234);
    chk("err sw write", 32'(bus_err), 32'h1);
    chk("sw write led untouched", 32'(led), 32'h0);
    cyc(2'b01, 9'h1FF, 16'h0);
    chk("unmapped read data", 32'(read_data), 32'h0000);
    chk("err sticky", 32'(bus_err), 32'h1);
    cyc(2'b11, 9'h005, 16'hFFFF);
    chk("illegal bus_err", 32'(bus_err), 32'h1);
    chk("err rd_cnt", 32'(rd_cnt), 32'd1);
    chk("err wr_cnt", 32'(wr_cnt), 32'd1);

    cyc(2'b10, 9'h000, 16'h5A5A);
    repeat (300) cyc(2'b01, 9'h000, 16'h0);
    chk("rd_cnt saturate", 32'(rd_cnt), 32'hFF);
    chk("sat read_data", 32'(read_data), 32'h5A5A);
    chk("sat wr_cnt", 32'(wr_cnt), 32'd2);

    reset = 1'b0;
    #1;
    chk("midreset read_data", 32'(read_data), 32'h0);
    chk("midreset led", 32'(led), 32'h0);
    chk("midreset bus_err", 32'(bus_err), 32'h0);
    chk("midreset rd_cnt", 32'(rd_cnt), 32'h0);
    chk("midreset wr_cnt", 32'(wr_cnt), 32'h0);
    #1 reset = 1'b1;
    cyc(2'b01, 9'h000, 16'h0);
    chk("post reset read", 32'(read_data), 32'h5A5A);
    chk("post reset rd_cnt", 32'(rd_cnt), 32'd1);
    cyc(2'b00, 9'h000, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
